// File: rtl/key_sched_ctrl.sv
// key_sched_ctrl: iterative AES-128 round-key scheduler and sequencer.
// Accepts a cipher key over valid/ready and expands it one round per cycle
// through a single shared g-function, holding all 11 round keys in a buffer.
// On start_i it streams the keys to the round datapath, ascending (0..10) for
// encryption or descending (10..0) for decryption.
//
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   key_valid_i/key_ready_o/key_i      cipher key handshake (W0 = key_i[127:96])
//   keys_ready_o       all 11 round keys valid in the buffer
//   start_i, dir_i     begin a stream (dir_i: 0 ascending, 1 descending)
//   rk_valid_o/rk_ready_i/rk_o/rk_idx_o/rk_last_o   round-key stream
//   busy_o             expanding or streaming
module key_sched_ctrl #(
  localparam int unsigned TEXT_WIDTH      = 128,
  localparam int unsigned BYTE_WIDTH      = 8,
  localparam int unsigned FOUR_BYTE_WIDTH = 32,
  localparam int unsigned IDX_WIDTH       = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  key_valid_i,
  output logic                  key_ready_o,
  input  logic [TEXT_WIDTH-1:0] key_i,
  output logic                  keys_ready_o,
  input  logic                  start_i,
  input  logic                  dir_i,
  output logic                  rk_valid_o,
  input  logic                  rk_ready_i,
  output logic [TEXT_WIDTH-1:0] rk_o,
  output logic [IDX_WIDTH-1:0]  rk_idx_o,
  output logic                  rk_last_o,
  output logic                  busy_o
);

  localparam int unsigned NUM_RK = 11;
  localparam logic [IDX_WIDTH-1:0] FIRST_IDX = IDX_WIDTH'(0);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(10);

  // FIPS-197 forward S-box, entry 0 leftmost.
  localparam logic [0:255][BYTE_WIDTH-1:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY,
    STREAM
  } state_e;

  function automatic logic [BYTE_WIDTH-1:0] sbox(input logic [BYTE_WIDTH-1:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [FOUR_BYTE_WIDTH-1:0] sub_word(input logic [FOUR_BYTE_WIDTH-1:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [BYTE_WIDTH-1:0] rcon(input logic [IDX_WIDTH-1:0] r);
    logic [BYTE_WIDTH-1:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  state_e                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   rnd_q, rnd_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic                   dir_q, dir_d;

  logic                   key_ready_q, key_ready_d;
  logic                   keys_ready_q, keys_ready_d;
  logic                   rk_valid_q, rk_valid_d;
  logic [TEXT_WIDTH-1:0]  rk_q, rk_d;
  logic [IDX_WIDTH-1:0]   rk_idx_q, rk_idx_d;
  logic                   rk_last_q, rk_last_d;
  logic                   busy_q, busy_d;

  logic [TEXT_WIDTH-1:0]  buffer [NUM_RK];

  logic                   accept;
  logic                   load_key;
  logic                   exp_we;
  logic [IDX_WIDTH-1:0]   prev_idx;
  logic [TEXT_WIDTH-1:0]  prev_rk;
  logic [FOUR_BYTE_WIDTH-1:0] t_word, n0, n1, n2, n3;
  logic [TEXT_WIDTH-1:0]  next_rk;

  // Shared g-function and XOR chain producing round key rnd from rnd-1.
  always_comb begin
    prev_idx = (rnd_q == FIRST_IDX) ? FIRST_IDX : rnd_q - IDX_WIDTH'(1);
    prev_rk  = buffer[prev_idx];
    t_word   = sub_word({prev_rk[23:0], prev_rk[31:24]}) ^ {rcon(rnd_q), 24'h0};
    n0       = prev_rk[127:96] ^ t_word;
    n1       = prev_rk[95:64]  ^ n0;
    n2       = prev_rk[63:32]  ^ n1;
    n3       = prev_rk[31:0]   ^ n2;
    next_rk  = {n0, n1, n2, n3};
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    rnd_d        = rnd_q;
    idx_d        = idx_q;
    dir_d        = dir_q;
    load_key     = 1'b0;
    exp_we       = 1'b0;
    accept       = key_valid_i && key_ready_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          load_key = 1'b1;
          rnd_d    = IDX_WIDTH'(1);
          state_d  = EXPAND;
        end
      end
      EXPAND: begin
        exp_we = 1'b1;
        rnd_d  = rnd_q + IDX_WIDTH'(1);
        if (rnd_q == LAST_IDX) state_d = READY;
      end
      READY: begin
        // A new key takes priority over a stream request.
        if (accept) begin
          load_key = 1'b1;
          rnd_d    = IDX_WIDTH'(1);
          state_d  = EXPAND;
        end else if (start_i) begin
          idx_d   = dir_i ? LAST_IDX : FIRST_IDX;
          dir_d   = dir_i;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (rk_ready_i) begin
          if (idx_q == (dir_q ? FIRST_IDX : LAST_IDX)) begin
            state_d = READY;
          end else begin
            idx_d = dir_q ? idx_q - IDX_WIDTH'(1) : idx_q + IDX_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    key_ready_d  = (state_d == IDLE) || (state_d == READY);
    keys_ready_d = (state_d == READY) || (state_d == STREAM);
    busy_d       = (state_d == EXPAND) || (state_d == STREAM);
    rk_valid_d   = (state_d == STREAM);
    rk_d         = rk_valid_d ? buffer[idx_d] : '0;
    rk_idx_d     = rk_valid_d ? idx_d : FIRST_IDX;
    rk_last_d    = rk_valid_d && (idx_d == (dir_d ? FIRST_IDX : LAST_IDX));
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      rnd_q        <= '0;
      idx_q        <= '0;
      dir_q        <= 1'b0;
      key_ready_q  <= 1'b0;
      keys_ready_q <= 1'b0;
      rk_valid_q   <= 1'b0;
      rk_q         <= '0;
      rk_idx_q     <= '0;
      rk_last_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rnd_q        <= rnd_d;
      idx_q        <= idx_d;
      dir_q        <= dir_d;
      key_ready_q  <= key_ready_d;
      keys_ready_q <= keys_ready_d;
      rk_valid_q   <= rk_valid_d;
      rk_q         <= rk_d;
      rk_idx_q     <= rk_idx_d;
      rk_last_q    <= rk_last_d;
      busy_q       <= busy_d;
    end
  end

  // Round-key buffer: data only, left unreset; a reset simply drops the write.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (load_key) buffer[0] <= key_i;
      if (exp_we)   buffer[rnd_q] <= next_rk;
    end
  end

  assign key_ready_o  = key_ready_q;
  assign keys_ready_o = keys_ready_q;
  assign rk_valid_o   = rk_valid_q;
  assign rk_o         = rk_q;
  assign rk_idx_o     = rk_idx_q;
  assign rk_last_o    = rk_last_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Bench for key_sched_ctrl: behavioural model (FIPS-197 expansion with an
// S-box derived from GF(2^8) inversion) checked against the DUT every cycle.
module tb_key_sched_ctrl;

  localparam int P_IDLE = 0;
  localparam int P_EXP  = 1;
  localparam int P_RDY  = 2;
  localparam int P_STR  = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key;
  logic         keys_ready;
  logic         start;
  logic         dir;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic         busy;

  key_sched_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .key_valid_i  (key_valid),
    .key_ready_o  (key_ready),
    .key_i        (key),
    .keys_ready_o (keys_ready),
    .start_i      (start),
    .dir_i        (dir),
    .rk_valid_o   (rk_valid),
    .rk_ready_i   (rk_ready),
    .rk_o         (rk),
    .rk_idx_o     (rk_idx),
    .rk_last_o    (rk_last),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb [256];
  logic [7:0]   rc [11];
  logic [127:0] m_keys [11];
  int           m_phase;
  int           m_cnt;
  bit           m_kr;
  bit           m_live;
  int           m_q [$];

  int           x_idx [$];
  logic [127:0] x_rk [$];
  bit           x_last [$];
  int           stream_cycles;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rc[0] = 8'h00;
    rc[1] = 8'h01;
    for (int r = 2; r < 11; r++) rc[r] = gf_mul(rc[r-1], 8'h02);
  endtask

  // Textbook word-oriented expansion into the 11 round keys.
  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // One clock: advance the model from pre-edge inputs, then compare after the edge.
  task automatic step();
    bit acc;
    acc = key_valid && m_kr;
    if (rk_valid && rk_ready) begin
      x_idx.push_back(int'(rk_idx));
      x_rk.push_back(rk);
      x_last.push_back(rk_last);
    end
    if (!rst_n) begin
      m_phase = P_IDLE;
      m_kr    = 1'b0;
      m_live  = 1'b1;
      m_q.delete();
    end else begin
      case (m_phase)
        P_IDLE: if (acc) begin model_expand(key); m_cnt = 10; m_phase = P_EXP; end
        P_EXP: begin
          m_cnt--;
          if (m_cnt == 0) m_phase = P_RDY;
        end
        P_RDY: begin
          if (acc) begin
            model_expand(key); m_cnt = 10; m_phase = P_EXP;
          end else if (start) begin
            m_q.delete();
            for (int i = 0; i < 11; i++) m_q.push_back(dir ? 10 - i : i);
            m_phase = P_STR;
          end
        end
        default: begin
          if (rk_ready) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_phase = P_RDY;
          end
        end
      endcase
      m_kr = (m_phase == P_IDLE) || (m_phase == P_RDY);
    end
    @(posedge clk);
    #1;
    if (m_live) begin
      chk("key_ready", 128'(key_ready), 128'(m_kr));
      chk("keys_ready", 128'(keys_ready), 128'((m_phase == P_RDY) || (m_phase == P_STR)));
      chk("busy", 128'(busy), 128'((m_phase == P_EXP) || (m_phase == P_STR)));
      chk("rk_valid", 128'(rk_valid), 128'(m_phase == P_STR));
      chk("rk_last", 128'(rk_last), 128'((m_phase == P_STR) && (m_q.size() == 1)));
      if (m_phase == P_STR) begin
        chk("rk", rk, m_keys[m_q[0]]);
        chk("rk_idx", 128'(rk_idx), 128'(m_q[0]));
      end else begin
        chk("rk_zero", rk, 128'h0);
      end
    end
  endtask

  task automatic load_key(input logic [127:0] k, output int lat);
    key = k;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (keys_ready) begin lat = n; break; end
    end
  endtask

  // mode 0: rk_ready held high; mode 1: ready pattern 1,0,0 with random start_i.
  task automatic do_stream(input bit d, input int mode);
    x_idx.delete(); x_rk.delete(); x_last.delete();
    start = 1'b1;
    dir   = d;
    step();
    start = 1'b0;
    dir   = 1'b0;
    stream_cycles = 0;
    for (int c = 0; c < 100 && rk_valid; c++) begin
      rk_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
      start    = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      dir      = 1'($urandom_range(0, 1));
      step();
      stream_cycles++;
    end
    rk_ready = 1'b0;
    start    = 1'b0;
    dir      = 1'b0;
  endtask

  logic [127:0] saved [11];
  int lat;

  initial begin
    rst_n = 1'b0; key_valid = 1'b0; key = '0; start = 1'b0; dir = 1'b0; rk_ready = 1'b0;
    m_phase = P_IDLE; m_kr = 1'b0; m_live = 1'b0; m_cnt = 0;
    build_tables();

    // Model pins.
    chk("pin_sbox_00", 128'(sb[8'h00]), 128'h63);
    chk("pin_sbox_53", 128'(sb[8'h53]), 128'hed);
    chk("pin_rcon_10", 128'(rc[10]), 128'h36);
    model_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("pin_fips_rk1", m_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("pin_fips_rk10", m_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reset.
    step();
    step();
    chk("rst_key_ready", 128'(key_ready), 128'h0);
    chk("rst_rk_idx", 128'(rk_idx), 128'h0);
    rst_n = 1'b1;
    step();
    chk("post_rst_key_ready", 128'(key_ready), 128'h1);

    // FIPS-197 key, ascending stream with rk_ready high.
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c, lat);
    chk("fips_latency", 128'(lat), 128'd10);
    do_stream(1'b0, 0);
    chk("fips_beats", 128'(x_rk.size()), 128'd11);
    if (x_rk.size() == 11) begin
      chk("fips_rk1", x_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
      chk("fips_rk10", x_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    end

    // All-zero key, descending.
    load_key(128'h0, lat);
    chk("zero_latency", 128'(lat), 128'd10);
    do_stream(1'b1, 0);
    chk("zero_beats", 128'(x_rk.size()), 128'd11);
    chk("zero_cycles", 128'(stream_cycles), 128'd11);
    if (x_rk.size() == 11) begin
      chk("zero_first_idx", 128'(x_idx[0]), 128'd10);
      chk("zero_first_rk", x_rk[0], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
      chk("zero_first_last", 128'(x_last[0]), 128'h0);
      chk("zero_last_idx", 128'(x_idx[10]), 128'd0);
      chk("zero_last_rk", x_rk[10], 128'h0);
      chk("zero_last_last", 128'(x_last[10]), 128'h1);
    end

    // Ascending stream with stalls and stray start_i.
    do_stream(1'b0, 1);
    chk("stall_beats", 128'(x_idx.size()), 128'd11);
    for (int i = 0; i < x_idx.size(); i++) chk("stall_idx", 128'(x_idx[i]), 128'(i));

    // Reset at cycle 5 of expansion.
    key = {$urandom(), $urandom(), $urandom(), $urandom()};
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    step();
    chk("abort_keys_ready", 128'(keys_ready), 128'h0);
    chk("abort_busy", 128'(busy), 128'h0);
    chk("abort_rk_idx", 128'(rk_idx), 128'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("abort_still_empty", 128'(keys_ready), 128'h0);
    load_key({$urandom(), $urandom(), $urandom(), $urandom()}, lat);
    chk("reload_latency", 128'(lat), 128'd10);

    // Key load and start together in READY: load wins.
    key = {$urandom(), $urandom(), $urandom(), $urandom()};
    key_valid = 1'b1;
    start = 1'b1;
    step();
    key_valid = 1'b0;
    start = 1'b0;
    chk("collide_no_stream", 128'(rk_valid), 128'h0);
    chk("collide_keys_ready", 128'(keys_ready), 128'h0);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (keys_ready) begin lat = n; break; end
    end
    chk("collide_latency", 128'(lat), 128'd10);

    // Back-to-back streams on the same key.
    do_stream(1'b1, 0);
    for (int i = 0; i < 11; i++) saved[i] = (i < x_rk.size()) ? x_rk[i] : 128'h0;
    step();
    chk("between_busy", 128'(busy), 128'h0);
    do_stream(1'b0, 0);
    chk("b2b_beats", 128'(x_rk.size()), 128'd11);
    for (int i = 0; i < x_rk.size() && i < 11; i++) chk("b2b_reverse", x_rk[i], saved[10 - i]);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      key_valid = ($urandom_range(0, 7) == 0);
      key       = {$urandom(), $urandom(), $urandom(), $urandom()};
      start     = ($urandom_range(0, 3) == 0);
      dir       = 1'($urandom_range(0, 1));
      rk_ready  = 1'($urandom_range(0, 1));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
